pulse_seq_gen: RTL
==================

Name: pulse_seq_gen

Overview:
Parametrised successor to the fixed read/write/read DAC pulse generator used for device programming-and-readback sweeps.
- Builds a sweep of interleaved read pulses and NUM_WRITE write slots, followed by a closing read.
- Write slots are selected per bit by a mask; segment widths and amplitudes are run-time programmable.
- A sweep can repeat a set number of times, with a start/busy/done handshake and abort.
- Drives the DAC code bus directly; downstream readback logic samples on a strobe.

Parameters:
DAC_W, 8, DAC code width
NUM_WRITE, 3, number of write slots per sweep
CNT_W, 22, segment width counter bits
ZERO_CODE, 128, DAC code for 0 V (idle/gap level)

Ports:
clk  in  1  system clock (20 ns)
reset  in  1  synchronous, active-high reset
start  in  1  begin sweep; honoured only when idle
abort  in  1  terminate sweep immediately
write_mask  in  NUM_WRITE  bit i=1: slot i drives write_amp; 0: slot i drives ZERO_CODE
read_amp  in  DAC_W  read pulse code
write_amp  in  DAC_W  write pulse code
read_width  in  CNT_W  read pulse length, cycles
write_width  in  CNT_W  write pulse length, cycles
gap_width  in  CNT_W  zero-level gap after every pulse, cycles
cycles  in  8  sweep repeat count
pulse  out  DAC_W  registered DAC code
busy  out  1  sweep in progress
done  out  1  one-cycle pulse on normal completion
sample_strobe  out  1  one-cycle pulse on the last cycle of each read pulse
slot_idx  out  $clog2(NUM_WRITE+1)  index of the current read/write pair

Behaviour:
- Reset: state IDLE, pulse=ZERO_CODE, busy=0, done=0, sample_strobe=0, slot_idx=0, counters=0.
- States: IDLE, READ_HI, READ_GAP, WRITE_HI, WRITE_GAP.
- Start:
  - start=1 in IDLE at edge k: latch write_mask, read_amp, write_amp, all widths and cycles.
  - Same edge: enter READ_HI, pulse<=latched read_amp, busy<=1.
  - Input changes during a sweep are ignored.
- Zero-value clamps: any width of 0 is treated as 1; cycles=0 is treated as 1.
- Sequence per sweep, for slot i = 0..NUM_WRITE-1:
  - READ_HI (read_width cycles), then READ_GAP (gap_width).
  - WRITE_HI (write_width; pulse=write_amp if mask[i] else ZERO_CODE), then WRITE_GAP (gap_width).
  - After the last slot: READ_HI, then READ_GAP, then either repeat or finish.
- Sweep length: L = (NUM_WRITE+1)*(read_width+gap_width) + NUM_WRITE*(write_width+gap_width) cycles. Total sweep time = L*cycles.
- Segment timing: each segment's code is held for exactly its width in cycles. Transitions have zero dead cycles.
- pulse is ZERO_CODE in every gap and in IDLE.
- sample_strobe is high only on the final cycle of each READ_HI, giving NUM_WRITE+1 strobes per sweep.
- slot_idx:
  - Increments on entry to each READ_HI after the first.
  - The closing read uses slot_idx = NUM_WRITE.
  - Resets to 0 on each repeat.
- Completion:
  - The edge ending the final READ_GAP of the last repeat returns to IDLE: busy<=0, done<=1 for one cycle.
  - busy is high for exactly L*cycles cycles.
- abort while busy:
  - Next edge: IDLE, pulse=ZERO_CODE, busy=0, sample_strobe=0.
  - done is not asserted.
- Simultaneous events:
  - abort+start in IDLE: abort wins, no sweep.
  - start while busy: ignored.
  - start on the done cycle: accepted (state is IDLE).
- reset mid-sweep: same effect as abort, plus all latched values are cleared.
- Counters: down-counter loaded with width-1 on segment entry; the segment ends at 0. No wrap-around is possible.

Decomposition:
- Package pulse_seq_pkg contains:
  - state enum (IDLE..WRITE_GAP);
  - ZERO_CODE default;
  - a function computing sweep length for benches.
- Sub-module seg_timer (CNT_W): inputs load and load_val; outputs count and expire. Instantiated once and reloaded on every segment entry.

Test Plan:
Common setup unless stated: NUM_WRITE=3, read_width=3, write_width=2, gap_width=2, read_amp=162, write_amp=201, cycles=1.
- mask=3'b111 -> code sequence 162x3, 128x2, 201x2, 128x2, repeated for each slot, then 162x3, 128x2; busy high 32 cycles; done at cycle 33; 4 strobes.
- mask=3'b010 -> only slot 1 shows 201; slots 0 and 2 hold 128 for 2 cycles each; total still 32 cycles.
- cycles=2 -> busy high 64 cycles; slot_idx returns to 0 at cycle 33; one done only; 8 strobes.
- abort at cycle 10 (inside slot 1 read) -> pulse=128 and busy=0 next cycle; no done; a subsequent start runs a full sweep.
- read_width=0, gap_width=0 -> each treated as 1 cycle; L = 4*2 + 3*3 = 17.
- start while busy and read_amp changed mid-sweep -> both ignored, original codes kept; start coincident with done -> new sweep begins with no IDLE gap cycle.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the programming/readback pulse sequencer.
package pulse_seq_pkg;

    // Segment currently being driven onto the DAC bus.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ_HI   = 3'd1,
        READ_GAP  = 3'd2,
        WRITE_HI  = 3'd3,
        WRITE_GAP = 3'd4
    } state_t;

    // DAC code for 0 V on a mid-scale offset-binary converter.
    localparam int ZERO_CODE_DEF = 128;

    // Cycles in one sweep, with zero widths clamped to one cycle.
    function automatic int sweep_len(input int num_write, input int read_width,
                                     input int write_width, input int gap_width);
        int rw;
        int ww;
        int gw;
        rw = (read_width  == 0) ? 1 : read_width;
        ww = (write_width == 0) ? 1 : write_width;
        gw = (gap_width   == 0) ? 1 : gap_width;
        return (num_write + 1) * (rw + gw) + num_write * (ww + gw);
    endfunction

endpackage

// File: rtl/pulse_seq_gen_seg_timer.sv
// Segment down-counter: loaded with (width-1) on segment entry, expires at 0.
module seg_timer #(
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    // Reload on segment entry, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign count  = r_count;
    assign expire = (r_count == '0);

endmodule

// File: rtl/pulse_seq_gen.sv
// Read/write/read DAC pulse sweep generator with repeat, abort and readback strobe.
//
// Handshake: start is sampled only while busy=0 and abort=0; on that edge the
// run-time settings are latched and busy rises. busy stays high for the whole
// sweep set; done pulses for one cycle on the edge busy falls after normal
// completion (never after abort or reset). start on the done cycle is honoured.
module pulse_seq_gen
    import pulse_seq_pkg::*;
#(
    parameter int DAC_W     = 8,
    parameter int NUM_WRITE = 3,
    parameter int CNT_W     = 22,
    parameter int ZERO_CODE = ZERO_CODE_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           abort,
    input  logic [NUM_WRITE-1:0]           write_mask,
    input  logic [DAC_W-1:0]               read_amp,
    input  logic [DAC_W-1:0]               write_amp,
    input  logic [CNT_W-1:0]               read_width,
    input  logic [CNT_W-1:0]               write_width,
    input  logic [CNT_W-1:0]               gap_width,
    input  logic [7:0]                     cycles,
    output logic [DAC_W-1:0]               pulse,
    output logic                           busy,
    output logic                           done,
    output logic                           sample_strobe,
    output logic [$clog2(NUM_WRITE+1)-1:0] slot_idx,
    output state_t                         state_dbg,
    output logic [CNT_W-1:0]               seg_count_dbg
);

    localparam int               SLOT_W    = $clog2(NUM_WRITE + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_WRITE);
    localparam logic [DAC_W-1:0]  ZERO      = DAC_W'(ZERO_CODE);

    // Registered state and settings latched at start.
    state_t                 r_state;
    logic [NUM_WRITE-1:0]   r_mask;
    logic [DAC_W-1:0]       r_read_amp;
    logic [DAC_W-1:0]       r_write_amp;
    logic [CNT_W-1:0]       r_rw_m1;
    logic [CNT_W-1:0]       r_ww_m1;
    logic [CNT_W-1:0]       r_gw_m1;
    logic [7:0]             r_cycles;
    logic [7:0]             r_rep;
    logic [SLOT_W-1:0]      r_slot;
    logic [DAC_W-1:0]       r_pulse;
    logic                   r_busy;
    logic                   r_done;

    // Next-state values and timer control.
    state_t                 w_state_nxt;
    logic [DAC_W-1:0]       w_pulse_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;
    logic [SLOT_W-1:0]      w_slot_nxt;
    logic [7:0]             w_rep_nxt;
    logic                   w_latch;
    logic                   w_load;
    logic [CNT_W-1:0]       w_load_val;
    logic                   w_expire;
    logic [CNT_W-1:0]       w_count;
    logic [NUM_WRITE-1:0]   w_mask_sh;
    logic [CNT_W-1:0]       w_in_rw_m1;
    logic [CNT_W-1:0]       w_in_ww_m1;
    logic [CNT_W-1:0]       w_in_gw_m1;
    logic [7:0]             w_in_cycles;

    // Zero widths and a zero repeat count behave as one.
    assign w_in_rw_m1  = (read_width  == '0) ? '0 : read_width  - CNT_W'(1);
    assign w_in_ww_m1  = (write_width == '0) ? '0 : write_width - CNT_W'(1);
    assign w_in_gw_m1  = (gap_width   == '0) ? '0 : gap_width   - CNT_W'(1);
    assign w_in_cycles = (cycles == 8'd0) ? 8'd1 : cycles;
    assign w_mask_sh   = r_mask >> r_slot;

    seg_timer #(
        .CNT_W (CNT_W)
    ) u_seg_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .count    (w_count),
        .expire   (w_expire)
    );

    // State, output and latched-setting registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_read_amp  <= '0;
            r_write_amp <= '0;
            r_rw_m1     <= '0;
            r_ww_m1     <= '0;
            r_gw_m1     <= '0;
            r_cycles    <= '0;
            r_rep       <= '0;
            r_slot      <= '0;
            r_pulse     <= ZERO;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rep   <= w_rep_nxt;
            r_slot  <= w_slot_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_latch) begin
                r_mask      <= write_mask;
                r_read_amp  <= read_amp;
                r_write_amp <= write_amp;
                r_rw_m1     <= w_in_rw_m1;
                r_ww_m1     <= w_in_ww_m1;
                r_gw_m1     <= w_in_gw_m1;
                r_cycles    <= w_in_cycles;
            end
        end
    end

    // Segment sequencing: each segment's code is registered on its entry edge.
    always_comb begin
        w_state_nxt = r_state;
        w_pulse_nxt = r_pulse;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_slot_nxt  = r_slot;
        w_rep_nxt   = r_rep;
        w_latch     = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
        if (r_state == IDLE) begin
            if (start && !abort) begin
                w_latch     = 1'b1;
                w_state_nxt = READ_HI;
                w_load      = 1'b1;
                w_load_val  = w_in_rw_m1;
                w_pulse_nxt = read_amp;
                w_busy_nxt  = 1'b1;
                w_slot_nxt  = '0;
                w_rep_nxt   = 8'd0;
            end
        end else if (abort) begin
            w_state_nxt = IDLE;
            w_pulse_nxt = ZERO;
            w_busy_nxt  = 1'b0;
        end else if (w_expire) begin
            case (r_state)
                READ_HI: begin
                    w_state_nxt = READ_GAP;
                    w_load      = 1'b1;
                    w_load_val  = r_gw_m1;
                    w_pulse_nxt = ZERO;
                end
                READ_GAP: begin
                    if (r_slot == LAST_SLOT) begin
                        if (r_rep + 8'd1 == r_cycles) begin
                            w_state_nxt = IDLE;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_pulse_nxt = ZERO;
                        end else begin
                            w_rep_nxt   = r_rep + 8'd1;
                            w_slot_nxt  = '0;
                            w_state_nxt = READ_HI;
                            w_load      = 1'b1;
                            w_load_val  = r_rw_m1;
                            w_pulse_nxt = r_read_amp;
                        end
                    end else begin
                        w_state_nxt = WRITE_HI;
                        w_load      = 1'b1;
                        w_load_val  = r_ww_m1;
                        w_pulse_nxt = w_mask_sh[0] ? r_write_amp : ZERO;
                    end
                end
                WRITE_HI: begin
                    w_state_nxt = WRITE_GAP;
                    w_load      = 1'b1;
                    w_load_val  = r_gw_m1;
                    w_pulse_nxt = ZERO;
                end
                WRITE_GAP: begin
                    w_slot_nxt  = r_slot + SLOT_W'(1);
                    w_state_nxt = READ_HI;
                    w_load      = 1'b1;
                    w_load_val  = r_rw_m1;
                    w_pulse_nxt = r_read_amp;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_pulse_nxt = ZERO;
                    w_busy_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign pulse         = r_pulse;
    assign busy          = r_busy;
    assign done          = r_done;
    assign slot_idx      = r_slot;
    assign sample_strobe = (r_state == READ_HI) && w_expire;
    assign state_dbg     = r_state;
    assign seg_count_dbg = w_count;

endmodule
